// File: rtl/dds_stream_monitor_if.sv
// rtl/dds_stream_monitor_if.sv - sample stream and window report bundle for dds_stream_monitor
interface dds_stream_monitor_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic signed [DATA_W-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic [CNT_W-1:0]         m_crossings;
    logic signed [DATA_W-1:0] m_max;
    logic signed [DATA_W-1:0] m_min;
    logic signed [DATA_W-1:0] m_mean;
    logic                     m_valid;
    logic                     m_ready;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_crossings, m_max, m_min, m_mean, m_valid
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_crossings, m_max, m_min, m_mean, m_valid
    );
endinterface

// File: rtl/dds_stream_monitor.sv
// rtl/dds_stream_monitor.sv - per-window zero-crossing / max / min monitor for the DDS sample stream
// Optional window mean enabled by defining DDS_MON_MEAN_EN.
module dds_stream_monitor #(
    parameter int DATA_W  = 16,
    parameter int WIN_LEN = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dds_stream_monitor_if.slave  mon
);
    localparam int LOG2_WIN = $clog2(WIN_LEN);
    localparam int SCNT_W   = LOG2_WIN + 1;
    localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(WIN_LEN - 1);

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t                   state_q;
    logic [SCNT_W-1:0]        samp_cnt_q;
    logic                     first_q;
    logic signed [DATA_W-1:0] prev_q;
    logic signed [DATA_W-1:0] max_q;
    logic signed [DATA_W-1:0] min_q;
    logic [CNT_W-1:0]         cross_q;

    logic signed [DATA_W-1:0] max_d;
    logic signed [DATA_W-1:0] min_d;
    logic [CNT_W-1:0]         cross_d;

    logic [CNT_W-1:0]         m_cross_q;
    logic signed [DATA_W-1:0] m_max_q;
    logic signed [DATA_W-1:0] m_min_q;
    logic                     m_valid_q;

    logic s_ready;
    logic accept;
    logic win_last;

    assign s_ready  = (state_q == ACCUM) && !reset;
    assign accept   = mon.s_valid && s_ready;
    assign win_last = (samp_cnt_q == LAST_IDX);

    // Running statistics including the sample on the input this cycle.
    always_comb begin
        max_d   = max_q;
        min_d   = min_q;
        cross_d = cross_q;
        if (!first_q) begin
            max_d = mon.s_data;
            min_d = mon.s_data;
        end else begin
            if (mon.s_data > max_q) begin
                max_d = mon.s_data;
            end
            if (mon.s_data < min_q) begin
                min_d = mon.s_data;
            end
            if (prev_q[DATA_W-1] && !mon.s_data[DATA_W-1] && (cross_q != {CNT_W{1'b1}})) begin
                cross_d = cross_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            samp_cnt_q <= '0;
            first_q    <= 1'b0;
            prev_q     <= '0;
            max_q      <= '0;
            min_q      <= '0;
            cross_q    <= '0;
            m_cross_q  <= '0;
            m_max_q    <= '0;
            m_min_q    <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (win_last) begin
                            m_cross_q  <= cross_d;
                            m_max_q    <= max_d;
                            m_min_q    <= min_d;
                            m_valid_q  <= 1'b1;
                            state_q    <= REPORT;
                            samp_cnt_q <= '0;
                            first_q    <= 1'b0;
                            prev_q     <= '0;
                            max_q      <= '0;
                            min_q      <= '0;
                            cross_q    <= '0;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + SCNT_W'(1);
                            first_q    <= 1'b1;
                            prev_q     <= mon.s_data;
                            max_q      <= max_d;
                            min_q      <= min_d;
                            cross_q    <= cross_d;
                        end
                    end
                end
                REPORT: begin
                    if (mon.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

`ifdef DDS_MON_MEAN_EN
    localparam int SUM_W = DATA_W + LOG2_WIN;

    logic signed [SUM_W-1:0]  sum_q;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  mean_full;
    logic signed [DATA_W-1:0] m_mean_q;

    assign sum_d     = sum_q + {{LOG2_WIN{mon.s_data[DATA_W-1]}}, mon.s_data};
    assign mean_full = sum_d >>> LOG2_WIN;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q    <= '0;
            m_mean_q <= '0;
        end else if ((state_q == ACCUM) && accept) begin
            if (win_last) begin
                sum_q    <= '0;
                m_mean_q <= mean_full[DATA_W-1:0];
            end else begin
                sum_q    <= sum_d;
            end
        end
    end

    assign mon.m_mean = m_mean_q;
`else
    assign mon.m_mean = '0;
`endif

    assign mon.s_ready     = s_ready;
    assign mon.m_crossings = m_cross_q;
    assign mon.m_max       = m_max_q;
    assign mon.m_min       = m_min_q;
    assign mon.m_valid     = m_valid_q;
endmodule

// File: tb/tb_dds_stream_monitor.sv
// tb/tb_dds_stream_monitor.sv - self-checking bench for dds_stream_monitor (WIN_LEN=8, CNT_W 16 and 2)
module tb_dds_stream_monitor;
    localparam int WIN = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dds_stream_monitor_if #(.DATA_W(16), .CNT_W(16)) ia ();
    dds_stream_monitor_if #(.DATA_W(16), .CNT_W(2))  ib ();

    dds_stream_monitor #(.DATA_W(16), .WIN_LEN(WIN), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (rst),
        .mon   (ia.slave)
    );

    dds_stream_monitor #(.DATA_W(16), .WIN_LEN(WIN), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (rst),
        .mon   (ib.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the window is a list of samples; a report is computed from the whole list.
    int win_q[$];
    bit in_rep = 1'b0;
    int e_cross = 0;
    int e_max = 0;
    int e_min = 0;
    int e_mean = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic make_report();
        int sum;
        int rem;
        e_cross = 0;
        e_max = win_q[0];
        e_min = win_q[0];
        sum = 0;
        foreach (win_q[i]) begin
            if (i > 0 && win_q[i-1] < 0 && win_q[i] >= 0) e_cross++;
            if (win_q[i] > e_max) e_max = win_q[i];
            if (win_q[i] < e_min) e_min = win_q[i];
            sum += win_q[i];
        end
        rem = ((sum % WIN) + WIN) % WIN;
        e_mean = (sum - rem) / WIN;
    endtask

    task automatic cycle(input bit r, input bit v, input int d, input bit rdy);
        int exp_mean;
        int sat;
        rst        = r;
        ia.s_valid = v;
        ib.s_valid = v;
        ia.s_data  = 16'(d);
        ib.s_data  = 16'(d);
        ia.m_ready = rdy;
        ib.m_ready = rdy;
        @(posedge clk);
        if (r) begin
            win_q.delete();
            in_rep = 1'b0;
            e_cross = 0; e_max = 0; e_min = 0; e_mean = 0;
        end else if (in_rep) begin
            if (rdy) in_rep = 1'b0;
        end else if (v) begin
            win_q.push_back(d);
            if (win_q.size() == WIN) begin
                make_report();
                in_rep = 1'b1;
                win_q.delete();
            end
        end
        #1;
`ifdef DDS_MON_MEAN_EN
        exp_mean = e_mean;
`else
        exp_mean = 0;
`endif
        sat = (e_cross > 3) ? 3 : e_cross;
        chk("s_ready_a", ia.s_ready, !in_rep && !r);
        chk("s_ready_b", ib.s_ready, !in_rep && !r);
        chk("m_valid_a", ia.m_valid, in_rep);
        chk("m_valid_b", ib.m_valid, in_rep);
        chk("cross_a", ia.m_crossings, e_cross);
        chk("cross_b", ib.m_crossings, sat);
        chk("max_a", ia.m_max, e_max);
        chk("max_b", ib.m_max, e_max);
        chk("min_a", ia.m_min, e_min);
        chk("min_b", ib.m_min, e_min);
        chk("mean_a", ia.m_mean, exp_mean);
        chk("mean_b", ib.m_mean, exp_mean);
    endtask

    typedef struct {
        bit v;
        int d;
        bit rdy;
        bit e_rdy;
        bit e_val;
        int e_cross;
        int e_max;
        int e_min;
    } vec_t;

    vec_t tbl[10];
    int basic[8];
    int sat_s[8];

    initial begin
        logic signed [15:0] rs;
        int gap_pos[3];

        basic = '{-3, -1, 2, 5, -4, -2, 0, 7};
        sat_s = '{-1, 1, -1, 1, -1, 1, -1, 1};
        tbl[0] = '{1, -3, 1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, -1, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{1,  2, 1, 1, 0, 0, 0, 0};
        tbl[3] = '{1,  5, 1, 1, 0, 0, 0, 0};
        tbl[4] = '{1, -4, 1, 1, 0, 0, 0, 0};
        tbl[5] = '{0, 99, 1, 1, 0, 0, 0, 0};
        tbl[6] = '{1, -2, 1, 1, 0, 0, 0, 0};
        tbl[7] = '{1,  0, 1, 1, 0, 0, 0, 0};
        tbl[8] = '{1,  7, 1, 0, 1, 2, 7, -4};
        tbl[9] = '{1, 50, 1, 1, 0, 2, 7, -4};

        // Reset state
        cycle(1'b1, 1'b1, 5, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b0);
        chk("rst_s_ready", ia.s_ready, 0);
        chk("rst_m_valid", ia.m_valid, 0);
        chk("rst_max", ia.m_max, 0);

        // Basic window, table driven (row 5 is an idle cycle, row 9 is the report handshake)
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk("tbl_s_ready", ia.s_ready, tbl[i].e_rdy);
            chk("tbl_m_valid", ia.m_valid, tbl[i].e_val);
            chk("tbl_cross", ia.m_crossings, tbl[i].e_cross);
            chk("tbl_max", ia.m_max, tbl[i].e_max);
            chk("tbl_min", ia.m_min, tbl[i].e_min);
        end

        // Back-pressure: report held for 5 cycles while the source keeps offering data
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, basic[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1000 + i, 1'b0);
            chk("bp_s_ready", ia.s_ready, 0);
            chk("bp_cross", ia.m_crossings, 2);
            chk("bp_max", ia.m_max, 7);
            chk("bp_min", ia.m_min, -4);
        end
        cycle(1'b0, 1'b0, 0, 1'b1);
        chk("bp_release_valid", ia.m_valid, 0);
        chk("bp_release_ready", ia.s_ready, 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 30 - 8 * i, 1'b1);
        chk("bp_next_max", ia.m_max, 30);
        chk("bp_next_min", ia.m_min, -26);
        cycle(1'b0, 1'b0, 0, 1'b1);

        // Input gaps at three random positions
        for (int g = 0; g < 3; g++) gap_pos[g] = $urandom_range(1, 7);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 3; g++) if (gap_pos[g] == i) cycle(1'b0, 1'b0, 77, 1'b1);
            cycle(1'b0, 1'b1, basic[i], 1'b1);
        end
        chk("gap_cross", ia.m_crossings, 2);
        chk("gap_max", ia.m_max, 7);
        chk("gap_min", ia.m_min, -4);
        cycle(1'b0, 1'b0, 0, 1'b1);

        // Crossing counter saturation on the CNT_W=2 instance
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, sat_s[i], 1'b1);
        chk("sat_cross_a", ia.m_crossings, 4);
        chk("sat_cross_b", ib.m_crossings, 3);
        chk("sat_max_b", ib.m_max, 1);
        chk("sat_min_b", ib.m_min, -1);
        cycle(1'b0, 1'b0, 0, 1'b1);

        // Reset mid-window discards the partial window
        cycle(1'b0, 1'b1, 100, 1'b1);
        cycle(1'b0, 1'b1, -100, 1'b1);
        cycle(1'b0, 1'b1, 100, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16, 1'b1);
        chk("rstw_cross", ia.m_crossings, 0);
        chk("rstw_max", ia.m_max, 16);
        chk("rstw_min", ia.m_min, 16);
`ifdef DDS_MON_MEAN_EN
        chk("rstw_mean", ia.m_mean, 16);
`else
        chk("rstw_mean", ia.m_mean, 0);
`endif

        // Reset during a pending report
        cycle(1'b1, 1'b0, 0, 1'b0);
        chk("rstr_valid", ia.m_valid, 0);

        // Randomized traffic against the window model
        for (int n = 0; n < 3000; n++) begin
            int d;
            if ($urandom_range(0, 3) == 0) begin
                rs = 16'($urandom);
                d = rs;
            end else begin
                d = $urandom_range(0, 40) - 20;
            end
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
